// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared FSM state encoding, ALU op code and mode constants for the multiply sequencer.
package alu_seq_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;
    localparam logic [1:0] ADD_OP = 2'b00;
    localparam logic MANUAL = 1'b0;
    localparam logic MULT   = 1'b1;
endpackage

// File: rtl/alu_mul_seq_start_edge.sv
// start_edge: turns the start request into a one-cycle event.
// Ports: clk, rst_n (async, active-low), start (level or pulse), evt (one-cycle start event).
// With EDGE_START=0 the input is already a pulse and passes straight through.
module start_edge #(
    parameter bit EDGE_START = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic evt
);
    logic start_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) start_q <= 1'b0;
        else        start_q <= start;
    assign evt = EDGE_START ? (start & ~start_q) : start;
endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: time-shares one W-bit ALU between manual ops and a shift-add unsigned multiply.
// Ports: clk, rst_n (async, active-low); start/mode/a/b/user_op from the user side;
// alu_a/alu_b/alu_op drive the ALU, alu_res/alu_cout come back combinationally;
// product (2W), busy, done, step_cnt go to the display path.
module alu_mul_seq
    import alu_seq_pkg::*;
#(
    parameter int         W          = 4,
    parameter logic [1:0] ADD_OP     = alu_seq_pkg::ADD_OP,
    parameter bit         EDGE_START = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     user_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [1:0]     alu_op,
    input  logic [W-1:0]   alu_res,
    input  logic           alu_cout,
    output logic [2*W-1:0] product,
    output logic           busy,
    output logic           done,
    output logic [2:0]     step_cnt
);
    logic         start_evt;
    state_t       state, state_nx;
    logic [W-1:0] acc_hi, mcand, mplier, acc_nx, mplier_nx;
    logic [W:0]   sum;
    logic         manual, last;

    start_edge #(.EDGE_START(EDGE_START)) u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .evt   (start_evt)
    );

    always_comb begin
        manual    = (state == IDLE) || (state == DONE);
        alu_a     = manual ? a : acc_hi;
        alu_b     = manual ? b : mcand;
        alu_op    = manual ? user_op : ADD_OP;
        // Partial-product add only when the current multiplier bit is set.
        sum       = mplier[0] ? {alu_cout, alu_res} : {1'b0, acc_hi};
        // The low sum bit shifts into the vacated top of the multiplier register.
        acc_nx    = sum[W:1];
        mplier_nx = {sum[0], mplier[W-1:1]};
        last      = step_cnt == 3'(W - 1);
        state_nx  = (state == IDLE) ? ((start_evt && mode == MULT) ? LOAD : IDLE) :
                    (state == LOAD) ? STEP :
                    (state == STEP) ? (last ? DONE : STEP) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            product  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_cnt <= '0;
            acc_hi   <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == LOAD) || (state_nx == STEP);
            done  <= state_nx == DONE;
            if (state == LOAD) begin
                mcand    <= a;
                mplier   <= b;
                acc_hi   <= '0;
                step_cnt <= '0;
            end
            if (state == STEP) begin
                acc_hi   <= acc_nx;
                mplier   <= mplier_nx;
                step_cnt <= step_cnt + 3'd1;
                if (last) product <= {acc_nx, mplier_nx};
            end
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed scoreboard bench for alu_mul_seq with a behavioural 4-bit ALU.
module tb_alu_mul_seq;
    logic       clk = 1'b0;
    logic       rst_n, start, mode;
    logic [3:0] a, b, alu_a, alu_b, alu_res;
    logic [1:0] user_op, alu_op;
    logic       alu_cout, busy, done;
    logic [7:0] product;
    logic [2:0] step_cnt;
    logic [7:0] sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .user_op  (user_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_res  (alu_res),
        .alu_cout (alu_cout),
        .product  (product),
        .busy     (busy),
        .done     (done),
        .step_cnt (step_cnt)
    );

    always_comb
        {alu_cout, alu_res} = (alu_op == 2'b00) ? {1'b0, alu_a} + {1'b0, alu_b} :
                              (alu_op == 2'b01) ? {1'b0, alu_a} - {1'b0, alu_b} :
                              (alu_op == 2'b10) ? {1'b0, alu_a & alu_b} : {1'b0, alu_a | alu_b};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mult(input logic [3:0] x, input logic [3:0] y, input bit hold);
        int n, nb;
        a = x; b = y; mode = 1'b1; start = 1'b0;
        tick;
        sb.push_back({4'd0, x} * {4'd0, y});
        start = 1'b1;
        n = 0; nb = 0;
        do begin
            tick;
            n++;
            nb += int'(busy);
            if (n == 2) chk("alu_op_busy", alu_op, 2'b00);
        end while (!done && n < 20);
        if (!hold) start = 1'b0;
        chk("latency", n, 6);
        chk("busy_cycles", nb, 5);
        chk("busy_in_done", busy, 0);
        chk("step_cnt", step_cnt, 4);
        chk("product", product, sb.pop_front());
        tick;
        chk("done_pulse", done, 0);
    endtask

    initial begin
        int d;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = 4'd3; b = 4'd5; user_op = 2'b01;
        tick;
        chk("rst_product", product, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_step_cnt", step_cnt, 0);
        rst_n = 1'b1;
        tick;
        chk("man_alu_a", alu_a, 3);
        chk("man_alu_b", alu_b, 5);
        chk("man_alu_op", alu_op, 2'b01);
        start = 1'b1;
        tick;
        tick;
        chk("mode0_ignored", busy, 0);
        start = 1'b0;
        mult(4'd3, 4'd5, 1'b0);
        mult(4'd15, 4'd15, 1'b0);
        mult(4'd0, 4'd9, 1'b0);
        mult(4'd2, 4'd7, 1'b1);
        d = 0;
        repeat (14) begin
            tick;
            d += int'(done);
        end
        chk("hold_single_done", d, 0);
        chk("hold_product", product, 8'h0E);
        start = 1'b0;
        a = 4'd2; b = 4'd7; mode = 1'b1;
        tick;
        sb.push_back(8'h0E);
        start = 1'b1;
        tick;
        tick;
        start = 1'b0;
        tick;
        start = 1'b1; a = 4'd1; mode = 1'b0;
        d = 0;
        repeat (12) begin
            tick;
            d += int'(done);
        end
        chk("retrigger_one_done", d, 1);
        chk("retrigger_product", product, sb.pop_front());
        start = 1'b0;
        a = 4'd9; b = 4'd9; mode = 1'b1;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_product", product, 0);
        chk("midrst_done", done, 0);
        chk("midrst_step_cnt", step_cnt, 0);
        d = 0;
        repeat (3) begin
            tick;
            d += int'(done);
        end
        chk("midrst_no_done", d, 0);
        rst_n = 1'b1;
        tick;
        mult(4'd9, 4'd9, 1'b0);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Sequencer that time-shares the single 4-bit ALU between manual operation (switch-selected op on A/B) and an unsigned shift-add multiply.
- Sits between the debounced buttons / number generator and the ALU.
- Owns the ALU operand and op inputs.
- Feeds the 8-bit product and a status nibble to the display path.

Parameters:
- W, 4, operand width; the product is 2*W bits.
- ADD_OP, 2'b00, ALU op code for addition.
- EDGE_START, 1, 1 = start is a level from the debouncer and is edge-detected internally; 0 = start is already a one-cycle pulse.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  multiply request; level or pulse per EDGE_START.
- mode  in  1  0 = manual pass-through, 1 = multiply; sampled only in IDLE.
- a  in  W  multiplicand / manual operand A.
- b  in  W  multiplier / manual operand B.
- user_op  in  2  manual ALU op.
- alu_a  out  W  to ALU A.
- alu_b  out  W  to ALU B.
- alu_op  out  2  to ALU op.
- alu_res  in  W  from ALU result (combinational).
- alu_cout  in  1  from ALU carry out.
- product  out  2W  last multiply result; holds until the next LOAD.
- busy  out  1  high from LOAD through the last STEP.
- done  out  1  one-cycle pulse in the DONE state.
- step_cnt  out  3  iterations completed (0..W), for display.

Behaviour:
- Reset is asynchronous, active-low. On reset:
  - state=IDLE; product=0; busy=0; done=0; step_cnt=0.
  - Internal acc_hi=0, mcand=0, mplier=0; edge register=0.
- Start event:
  - EDGE_START=1: start & ~start_q, with start_q registered every cycle.
  - EDGE_START=0: start itself.
- ALU mux:
  - In IDLE or DONE: alu_a=a, alu_b=b, alu_op=user_op (manual).
  - In LOAD or STEP: alu_a=acc_hi, alu_b=mcand, alu_op=ADD_OP.
- FSM: IDLE -> LOAD -> STEP (W cycles) -> DONE -> IDLE.
- IDLE:
  - Start event with mode=1 -> LOAD. Start event with mode=0 is ignored.
  - Start events in any other state are dropped, not queued.
- LOAD (1 cycle):
  - mcand<=a; mplier<=b; acc_hi<=0; step_cnt<=0; busy=1.
  - product is not cleared here.
- STEP (one bit per cycle):
  - If mplier[0]=1: {c,s}={alu_cout,alu_res}. Else: {c,s}={0,acc_hi}.
  - Shift right: acc_hi<={c,s[W-1:1]}; mplier<={s[0],mplier[W-1:1]}; step_cnt++.
  - After the W-th step (step_cnt reaches W): product<={acc_hi_next,mplier_next} -> DONE.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- Latency: start event to done = W+2 cycles, i.e. 6 for W=4. product is updated on the same edge that enters DONE.
- Boundaries:
  - a=0 or b=0 gives product=0 after the full W steps; there is no early exit.
  - Max case 15*15=225 (0xE1): carry must be captured, with no overflow in 2W bits.
  - a/b changing during busy has no effect; operands are latched in LOAD.
  - mode changing during busy has no effect.
  - Holding start high (EDGE_START=1) triggers exactly once per rising edge.
  - A rising edge arriving in the DONE cycle is dropped.
  - Reset mid-STEP returns to IDLE in the same instant, product=0, with no done pulse.
- busy and done are registered (Moore) outputs; they are never high together.

Decomposition:
- Package alu_seq_pkg:
  - state enum {IDLE, LOAD, STEP, DONE} (2-bit encoding).
  - ADD_OP constant.
  - MANUAL/MULT mode constants.
- Sub-module: start_edge (flop plus rising-edge detect, bypassed when EDGE_START=0).
- Datapath and FSM stay in one module.

Test Plan:
- Reset then idle, mode=0, a=3, b=5, user_op=2'b01 -> alu_a=3, alu_b=5, alu_op=01; busy=0, product=0.
- mode=1, a=3, b=5, one start rise -> busy for 5 cycles, done pulse at cycle 6, product=8'h0F, step_cnt=4.
- a=15, b=15 -> product=8'hE1. Then a=0, b=9 -> product=8'h00, still 6-cycle latency.
- Start held high 20 cycles with a=2, b=7 -> exactly one done pulse, product=8'h0E.
- Second start rise and a=1 change during busy -> ignored; the first result holds (2*7=0x0E).
- Reset asserted at STEP cycle 2 of 9*9 -> immediately state=IDLE, busy=0, product=0, no done. After release, a new 9*9 yields 8'h51.
